gerenciador_atributos: RTL and testbench

//  Owns the pet's three vital attributes (fome, felicidade, sono) and feeds them to the state

---
 rtl/gerenciador_atributos_pkg.sv | 23 ++
 rtl/gerenciador_atributos_atributo_saturado.sv | 37 +++
 rtl/gerenciador_atributos.sv | 94 +++++++++
 tb/tb_gerenciador_atributos.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gerenciador_atributos_pkg.sv
// Shared definitions for the pet attribute manager: the controller's one-hot state
// encodings, the attribute indices, and a saturating 8-bit add used for step sizes.
package gerenciador_atributos_pkg;

  localparam logic [3:0] IDLE       = 4'b0000;
  localparam logic [3:0] DORMINDO   = 4'b0001;
  localparam logic [3:0] COMENDO    = 4'b0010;
  localparam logic [3:0] DANDO_AULA = 4'b0100;
  localparam logic [3:0] MORTO      = 4'b1000;

  // Index order matches the alerta bit order: [0] fome, [1] sono, [2] felicidade.
  localparam int N_ATTR   = 3;
  localparam int ATTR_FOM = 0;
  localparam int ATTR_SON = 1;
  localparam int ATTR_FEL = 2;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/gerenciador_atributos_atributo_saturado.sv
// One saturating 8-bit attribute register: loads INICIAL on reset, and on en
// adds or subtracts step, clamping to 0..255.
module atributo_saturado
  #(
    parameter logic [7:0] INICIAL = 8'd200
  )
  (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       inc,
    input  logic [7:0] step,
    output logic [7:0] valor
  );

  logic [8:0] soma;
  logic [7:0] valor_next;

  always_comb begin
    soma       = {1'b0, valor} + {1'b0, step};
    valor_next = valor;
    if (inc) begin
      valor_next = soma[8] ? 8'hFF : soma[7:0];
    end else begin
      valor_next = (valor < step) ? 8'd0 : (valor - step);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valor <= INICIAL;
    end else if (en) begin
      valor <= valor_next;
    end
  end

endmodule

// File: rtl/gerenciador_atributos.sv
// Pet vital-attribute manager: a prescaler produces the update edge, the controller's
// estado picks decay/replenish per attribute, and alerta flags attributes below LIMIAR.
module gerenciador_atributos
  import gerenciador_atributos_pkg::*;
  #(
    parameter int         TICK_DIV = 25_000_000,
    parameter logic [7:0] INICIAL  = 8'd200,
    parameter logic [7:0] DECAI    = 8'd1,
    parameter logic [7:0] GANHO    = 8'd8,
    parameter logic [7:0] LIMIAR   = 8'd32
  )
  (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] estado,
    output logic [7:0] fome,
    output logic [7:0] felicidade,
    output logic [7:0] sono,
    output logic       tick,
    output logic [2:0] alerta
  );

  localparam int         PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0] DECAI_2   = sat_add8(DECAI, DECAI);

  logic [PW-1:0] prescaler_reg;
  logic          update;

  logic [7:0] step  [N_ATTR];
  logic [7:0] valor [N_ATTR];
  logic       inc   [N_ATTR];
  logic       hold;

  assign update = (prescaler_reg == PRE_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_reg <= '0;
      tick          <= 1'b0;
    end else begin
      tick          <= update;
      prescaler_reg <= update ? '0 : prescaler_reg + 1'b1;
    end
  end

  // Non one-hot encodings fall through to the IDLE behaviour (all decay by DECAI).
  always_comb begin
    hold = 1'b0;
    for (int i = 0; i < N_ATTR; i++) begin
      inc[i]  = 1'b0;
      step[i] = DECAI;
    end
    case (estado)
      DORMINDO: begin
        inc[ATTR_SON]  = 1'b1;
        step[ATTR_SON] = GANHO;
      end
      COMENDO: begin
        inc[ATTR_FOM]  = 1'b1;
        step[ATTR_FOM] = GANHO;
      end
      DANDO_AULA: begin
        step[ATTR_FOM] = DECAI_2;
        step[ATTR_SON] = DECAI_2;
        inc[ATTR_FEL]  = 1'b1;
        step[ATTR_FEL] = GANHO;
      end
      MORTO:   hold = 1'b1;
      default: hold = 1'b0;
    endcase
  end

  generate
    for (genvar gi = 0; gi < N_ATTR; gi++) begin : g_attr
      atributo_saturado #(
        .INICIAL(INICIAL)
      ) u_attr (
        .clk  (clk),
        .rst  (rst),
        .en   (update && !hold),
        .inc  (inc[gi]),
        .step (step[gi]),
        .valor(valor[gi])
      );
      assign alerta[gi] = (valor[gi] < LIMIAR);
    end
  endgenerate

  assign fome       = valor[ATTR_FOM];
  assign sono       = valor[ATTR_SON];
  assign felicidade = valor[ATTR_FEL];

endmodule

// File: tb/tb_gerenciador_atributos.sv
// Bench for gerenciador_atributos: two instances (INICIAL=200 and INICIAL=3) share the
// stimulus; a behavioural model is compared every cycle, plus hand-computed checkpoints.
module tb_gerenciador_atributos;

  localparam int TDIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] estado = 4'b0000;

  logic [7:0] fome_a, fel_a, sono_a, fome_b, fel_b, sono_b;
  logic       tick_a, tick_b;
  logic [2:0] alerta_a, alerta_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gerenciador_atributos #(.TICK_DIV(TDIV), .INICIAL(8'd200), .DECAI(8'd1), .GANHO(8'd8), .LIMIAR(8'd32)) dut_a (
    .clk(clk), .rst(rst), .estado(estado),
    .fome(fome_a), .felicidade(fel_a), .sono(sono_a), .tick(tick_a), .alerta(alerta_a)
  );

  gerenciador_atributos #(.TICK_DIV(TDIV), .INICIAL(8'd3), .DECAI(8'd1), .GANHO(8'd8), .LIMIAR(8'd32)) dut_b (
    .clk(clk), .rst(rst), .estado(estado),
    .fome(fome_b), .felicidade(fel_b), .sono(sono_b), .tick(tick_b), .alerta(alerta_b)
  );

  // ---------------- behavioural model ----------------
  int m_init [2] = '{200, 3};
  int m_fome [2];
  int m_sono [2];
  int m_fel  [2];
  int m_cycle = 0;   // clock edges since reset released
  int m_tick  = 0;
  bit m_valid = 0;

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_fome[k] = m_init[k];
        m_sono[k] = m_init[k];
        m_fel[k]  = m_init[k];
      end
      m_cycle = 0;
      m_tick  = 0;
      m_valid = 1;
    end else begin
      m_cycle = m_cycle + 1;
      m_tick  = (m_cycle % TDIV == 0) ? 1 : 0;
      if (m_tick == 1) begin
        for (int k = 0; k < 2; k++) begin
          case (estado)
            4'b0001: begin m_fome[k] = clamp(m_fome[k]-1); m_sono[k] = clamp(m_sono[k]+8); m_fel[k] = clamp(m_fel[k]-1); end
            4'b0010: begin m_fome[k] = clamp(m_fome[k]+8); m_sono[k] = clamp(m_sono[k]-1); m_fel[k] = clamp(m_fel[k]-1); end
            4'b0100: begin m_fome[k] = clamp(m_fome[k]-2); m_sono[k] = clamp(m_sono[k]-2); m_fel[k] = clamp(m_fel[k]+8); end
            4'b1000: ;
            default: begin m_fome[k] = clamp(m_fome[k]-1); m_sono[k] = clamp(m_sono[k]-1); m_fel[k] = clamp(m_fel[k]-1); end
          endcase
        end
      end
    end
  end

  function automatic int m_alerta(input int k);
    return ((m_fel[k] < 32) ? 4 : 0) + ((m_sono[k] < 32) ? 2 : 0) + ((m_fome[k] < 32) ? 1 : 0);
  endfunction

  task automatic chk(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("a.fome",   int'(fome_a),   m_fome[0]);
      chk("a.sono",   int'(sono_a),   m_sono[0]);
      chk("a.fel",    int'(fel_a),    m_fel[0]);
      chk("a.tick",   int'(tick_a),   m_tick);
      chk("a.alerta", int'(alerta_a), m_alerta(0));
      chk("b.fome",   int'(fome_b),   m_fome[1]);
      chk("b.sono",   int'(sono_b),   m_sono[1]);
      chk("b.fel",    int'(fel_b),    m_fel[1]);
      chk("b.tick",   int'(tick_b),   m_tick);
      chk("b.alerta", int'(alerta_b), m_alerta(1));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cyc(n);
    rst = 1'b0;
  endtask

  task automatic chk_a3(input string name, input int f, input int s, input int h);
    chk({name, ".fome"}, int'(fome_a), f);
    chk({name, ".sono"}, int'(sono_a), s);
    chk({name, ".fel"},  int'(fel_a),  h);
  endtask

  initial begin
    int ticks;
    int len;
    logic [3:0] e;

    // 1: reset values, first update on the 4th edge after release (also test 5 on dut_b)
    estado = 4'b0000;
    do_reset(2);
    chk_a3("t1.reset", 200, 200, 200);
    chk("t1.tick", int'(tick_a), 0);
    chk("t1.alerta_a", int'(alerta_a), 0);
    chk("t5.alerta_b_init", int'(alerta_b), 7);
    cyc(3);
    chk("t1.no_tick_yet", int'(tick_a), 0);
    chk("t1.no_change_yet", int'(fome_a), 200);
    cyc(1);
    chk("t1.first_tick", int'(tick_a), 1);
    chk("t1.first_fome", int'(fome_a), 199);
    $display("txn reset+first tick: fome=%0d sono=%0d fel=%0d", fome_a, sono_a, fel_a);

    // 5: INICIAL=3 under IDLE for 4 ticks reaches 0 without wrapping, then MORTO holds
    cyc(12);
    chk("t5.fome_b", int'(fome_b), 0);
    chk("t5.sono_b", int'(sono_b), 0);
    chk("t5.fel_b",  int'(fel_b),  0);
    chk("t5.alerta_b", int'(alerta_b), 7);
    estado = 4'b1000;
    cyc(12);
    chk("t5.morto_b", int'(fome_b), 0);
    chk_a3("t5.morto_a", 196, 196, 196);
    $display("txn idle4+morto3: a=%0d b=%0d alerta_b=%0d", fome_a, fome_b, alerta_b);

    // 2: IDLE 3 ticks, tick exactly once per 4 cycles
    estado = 4'b0000;
    do_reset(2);
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (tick_a) ticks++;
    end
    chk_a3("t2.idle3", 197, 197, 197);
    chk("t2.tick_count", ticks, 3);
    $display("txn idle3: fome=%0d ticks=%0d", fome_a, ticks);

    // 3: COMENDO 7 ticks saturates fome at 255
    estado = 4'b0010;
    do_reset(2);
    cyc(28);
    chk_a3("t3.comendo7", 255, 193, 193);
    $display("txn comendo7: fome=%0d sono=%0d fel=%0d", fome_a, sono_a, fel_a);

    // 4: estado toggled mid-interval is ignored; only the value at the update edge counts
    estado = 4'b0100;
    do_reset(2);
    cyc(1);
    estado = 4'b1000;
    cyc(1);
    estado = 4'b0010;
    cyc(1);
    estado = 4'b0100;
    cyc(1);
    chk_a3("t4.aula1", 198, 198, 208);
    $display("txn aula1: fome=%0d sono=%0d fel=%0d", fome_a, sono_a, fel_a);

    // 6: reset mid-count discards the partial interval
    estado = 4'b0000;
    do_reset(2);
    cyc(6);
    chk("t6.before", int'(fome_a), 199);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk_a3("t6.reset", 200, 200, 200);
    cyc(3);
    chk("t6.no_tick", int'(tick_a), 0);
    cyc(1);
    chk("t6.tick", int'(tick_a), 1);
    chk("t6.fome", int'(fome_a), 199);
    $display("txn midreset: fome=%0d tick=%0d", fome_a, tick_a);

    // Randomized segments: arbitrary (including non one-hot) estado, occasional resets
    for (int s = 0; s < 60; s++) begin
      e   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) e = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) e = 4'b0000;
      len = $urandom_range(1, 40);
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        cyc($urandom_range(1, 3));
        rst = 1'b0;
      end
      estado = e;
      cyc(len);
      $display("txn rand %0d: estado=%b len=%0d a=%0d/%0d/%0d b=%0d/%0d/%0d", s, e, len,
               fome_a, sono_a, fel_a, fome_b, sono_b, fel_b);
    end

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
